bldcm_pwm_core: RTL and testbench

- Next-generation six-step BLDC commutation core.
- Advances a commutation step counter at a programmable rate, in either direction.
- Chops the high-side gates with a parametrised-resolution PWM and inserts per-leg dead time before any gate turns on.
- Sits between the CPU-facing register block and the gate-driver pins; drives the six gate outputs directly.

---
 rtl/bldcm_pwm_core_pkg.sv | 47 ++++
 rtl/bldcm_dead_time_leg.sv | 64 ++++++
 rtl/bldcm_pwm_core.sv | 141 ++++++++++++++
 tb/tb_bldcm_pwm_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bldcm_pwm_core_pkg.sv
// bldcm_pwm_core_pkg: shared constants for the six-step commutation core.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: step count, direction encoding, commutation table (high/low leg one-hots).
// Leg one-hot bit order: bit0 = U, bit1 = V, bit2 = W.
package bldcm_pwm_core_pkg;

  localparam int unsigned STEP_COUNT = 6;
  localparam logic [2:0]  STEP_MAX   = 3'(STEP_COUNT - 1);

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_e;

  localparam logic [2:0] LEG_U = 3'b001;
  localparam logic [2:0] LEG_V = 3'b010;
  localparam logic [2:0] LEG_W = 3'b100;

  typedef struct packed {
    logic [2:0] hi;  // leg whose high side is chopped by PWM
    logic [2:0] lo;  // leg whose low side is held on
  } comm_t;

  function automatic comm_t comm_lookup(input logic [2:0] step);
    comm_t c;
    case (step)
      3'd0:    c = '{hi: LEG_U, lo: LEG_V};
      3'd1:    c = '{hi: LEG_U, lo: LEG_W};
      3'd2:    c = '{hi: LEG_V, lo: LEG_W};
      3'd3:    c = '{hi: LEG_V, lo: LEG_U};
      3'd4:    c = '{hi: LEG_W, lo: LEG_U};
      3'd5:    c = '{hi: LEG_W, lo: LEG_V};
      default: c = '{hi: 3'b000, lo: 3'b000};
    endcase
    return c;
  endfunction

  // Next step modulo STEP_COUNT in the requested direction.
  function automatic logic [2:0] step_next(input logic [2:0] step, input dir_e dir);
    logic [2:0] n;
    if (dir == DIR_FWD) n = (step >= STEP_MAX) ? 3'd0 : step + 3'd1;
    else                n = (step == 3'd0) ? STEP_MAX : step - 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/bldcm_dead_time_leg.sv
// bldcm_dead_time_leg: one half-bridge leg, dead-time counter plus registered gates.
// Latency: 1 clock from request to gate (assertion additionally waits for dead time).
// Backpressure: none; a request that is not yet eligible simply waits.
// Ports: iClock, iReset_n, iHighReq/iLowReq (gate requests) -> oHigh/oLow (gate drives).
module bldcm_dead_time_leg
  import bldcm_pwm_core_pkg::*;
#(
  parameter int unsigned pDeadTime  = 4,
  parameter int unsigned pDeadWidth = 8
) (
  input  logic iClock,
  input  logic iReset_n,
  input  logic iHighReq,
  input  logic iLowReq,
  output logic oHigh,
  output logic oLow
);

  localparam logic [pDeadWidth-1:0] DEAD_MAX = pDeadWidth'(pDeadTime);

  logic [pDeadWidth-1:0] dead_cnt_q, dead_cnt_d;
  logic                  high_q, high_d;
  logic                  low_q, low_d;
  logic                  eligible;

  always_comb begin
    dead_cnt_d = dead_cnt_q;
    high_d     = 1'b0;
    low_d      = 1'b0;
    eligible   = (dead_cnt_q == DEAD_MAX);

    // Counter measures how long both gates have been off, saturating.
    if (high_q || low_q)          dead_cnt_d = '0;
    else if (dead_cnt_q != DEAD_MAX) dead_cnt_d = dead_cnt_q + pDeadWidth'(1);

    if (pDeadTime == 0) begin
      // No dead time: straight registered follow, high side wins a conflict.
      high_d = iHighReq;
      low_d  = iLowReq & ~iHighReq;
    end else begin
      // An already-on gate stays on while requested; a new turn-on needs the
      // opposite gate off and the full dead time elapsed. Conflicting
      // requests turn both off.
      high_d = iHighReq & ~iLowReq & (high_q | (~low_q & eligible));
      low_d  = iLowReq & ~iHighReq & (low_q | (~high_q & eligible));
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      dead_cnt_q <= DEAD_MAX;  // legs start eligible
      high_q     <= 1'b0;
      low_q      <= 1'b0;
    end else begin
      dead_cnt_q <= dead_cnt_d;
      high_q     <= high_d;
      low_q      <= low_d;
    end
  end

  assign oHigh = high_q;
  assign oLow  = low_q;

endmodule

// File: rtl/bldcm_pwm_core.sv
// bldcm_pwm_core: six-step BLDC commutation with PWM high-side chopping and dead time.
// Latency: gates are registered, 1 clock after request (plus dead time on turn-on).
// Backpressure: none; iStop freezes the step timer and forces gate requests low.
// Ports: iDiv/iDir set step rate and direction, iDuty sets PWM on-count,
//   iPhaseUpdate/iLatchPhaseUpdate load the step, oPhase/oStepTick report it,
//   oUh..oWl drive the gates. Optional port iBrake exists when BLDCM_BRAKE_EN is defined.
module bldcm_pwm_core
  import bldcm_pwm_core_pkg::*;
#(
  parameter int unsigned pPwmWidth  = 8,
  parameter int unsigned pDeadTime  = 4,
  parameter int unsigned pDeadWidth = 8
) (
  input  logic                 iClock,
  input  logic                 iReset_n,
  input  logic [31:0]          iDiv,
  input  logic                 iStop,
  input  logic                 iDir,
  input  logic [pPwmWidth-1:0] iDuty,
  input  logic [2:0]           iPhaseUpdate,
  input  logic                 iLatchPhaseUpdate,
`ifdef BLDCM_BRAKE_EN
  input  logic                 iBrake,
`endif
  output logic [2:0]           oPhase,
  output logic                 oStepTick,
  output logic                 oUh,
  output logic                 oUl,
  output logic                 oVh,
  output logic                 oVl,
  output logic                 oWh,
  output logic                 oWl
);

  logic [2:0]           step_q, step_d;
  logic [31:0]          timer_q, timer_d;
  logic                 tick_q, tick_d;
  logic [pPwmWidth-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [pPwmWidth-1:0] duty_shadow_q, duty_shadow_d;
  logic [pPwmWidth-1:0] duty_eff;
  logic                 pwm_on;
  logic                 brake_act;
  comm_t                comm;
  logic [2:0]           high_req, low_req;

`ifdef BLDCM_BRAKE_EN
  assign brake_act = iBrake;
`else
  assign brake_act = 1'b0;
`endif

  // Step timer and step register. Latch beats stop and beats a timer advance.
  always_comb begin
    step_d  = step_q;
    timer_d = timer_q;
    tick_d  = 1'b0;
    if (iLatchPhaseUpdate) begin
      timer_d = '0;
      if (iPhaseUpdate <= STEP_MAX) step_d = iPhaseUpdate;
    end else if (!iStop) begin
      if (iDiv == 32'd0) begin
        timer_d = '0;
      end else if (timer_q >= iDiv - 32'd1) begin
        // ">=" so that shrinking iDiv below the running count advances at once.
        timer_d = '0;
        step_d  = step_next(step_q, dir_e'(iDir));
        tick_d  = 1'b1;
      end else begin
        timer_d = timer_q + 32'd1;
      end
    end
  end

  // PWM: the shadow is loaded at count 0 and that same cycle already uses the
  // new duty, so each period runs entirely on one duty value.
  always_comb begin
    pwm_cnt_d     = pwm_cnt_q + pPwmWidth'(1);
    duty_shadow_d = duty_shadow_q;
    duty_eff      = duty_shadow_q;
    if (pwm_cnt_q == '0) begin
      duty_shadow_d = iDuty;
      duty_eff      = iDuty;
    end
    pwm_on = (pwm_cnt_q < duty_eff);
  end

  // Gate requests: stop > brake > commutation table.
  always_comb begin
    comm     = comm_lookup(step_q);
    high_req = 3'b000;
    low_req  = 3'b000;
    if (iStop) begin
      high_req = 3'b000;
      low_req  = 3'b000;
    end else if (brake_act) begin
      high_req = 3'b000;
      low_req  = 3'b111;
    end else begin
      high_req = pwm_on ? comm.hi : 3'b000;
      low_req  = comm.lo;
    end
  end

  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      step_q        <= 3'd0;
      timer_q       <= '0;
      tick_q        <= 1'b0;
      pwm_cnt_q     <= '0;
      duty_shadow_q <= '0;
    end else begin
      step_q        <= step_d;
      timer_q       <= timer_d;
      tick_q        <= tick_d;
      pwm_cnt_q     <= pwm_cnt_d;
      duty_shadow_q <= duty_shadow_d;
    end
  end

  bldcm_dead_time_leg #(.pDeadTime(pDeadTime), .pDeadWidth(pDeadWidth)) u_leg_u (
    .iClock(iClock), .iReset_n(iReset_n),
    .iHighReq(high_req[0]), .iLowReq(low_req[0]),
    .oHigh(oUh), .oLow(oUl)
  );

  bldcm_dead_time_leg #(.pDeadTime(pDeadTime), .pDeadWidth(pDeadWidth)) u_leg_v (
    .iClock(iClock), .iReset_n(iReset_n),
    .iHighReq(high_req[1]), .iLowReq(low_req[1]),
    .oHigh(oVh), .oLow(oVl)
  );

  bldcm_dead_time_leg #(.pDeadTime(pDeadTime), .pDeadWidth(pDeadWidth)) u_leg_w (
    .iClock(iClock), .iReset_n(iReset_n),
    .iHighReq(high_req[2]), .iLowReq(low_req[2]),
    .oHigh(oWh), .oLow(oWl)
  );

  assign oPhase    = step_q;
  assign oStepTick = tick_q;

endmodule

// File: tb/tb_bldcm_pwm_core.sv
// tb_bldcm_pwm_core: directed plus randomized bench with a cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bldcm_pwm_core;

  localparam int PW  = 8;
  localparam int DT  = 4;
  localparam int PER = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   div;
  logic          stop, dir, latch, brake;
  logic [PW-1:0] duty;
  logic [2:0]    pu;

  logic [2:0] o_phase;
  logic       o_tick, o_uh, o_ul, o_vh, o_vl, o_wh, o_wl;

  always #5 clk = ~clk;

  bldcm_pwm_core #(.pPwmWidth(PW), .pDeadTime(DT), .pDeadWidth(8)) dut (
    .iClock(clk), .iReset_n(rst_n), .iDiv(div), .iStop(stop), .iDir(dir),
    .iDuty(duty), .iPhaseUpdate(pu), .iLatchPhaseUpdate(latch),
`ifdef BLDCM_BRAKE_EN
    .iBrake(brake),
`endif
    .oPhase(o_phase), .oStepTick(o_tick),
    .oUh(o_uh), .oUl(o_ul), .oVh(o_vh), .oVl(o_vl), .oWh(o_wh), .oWl(o_wl)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: which leg is driven high / low in each step (0=U,1=V,2=W).
  int hi_leg [6] = '{0, 0, 1, 1, 2, 2};
  int lo_leg [6] = '{1, 2, 2, 0, 0, 1};

  int     m_step, m_timer, m_tick, m_pwm, m_period_duty;
  int     m_h [3];
  int     m_l [3];
  longint m_busy [3];   // last cycle in which the leg had any gate on
  longint m_cyc = 0;

  task automatic model_reset();
    m_step = 0; m_timer = 0; m_tick = 0; m_pwm = 0; m_period_duty = 0;
    for (int k = 0; k < 3; k++) begin
      m_h[k] = 0; m_l[k] = 0; m_busy[k] = m_cyc - 1000;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_next();
    int duty_now, on;
    int hreq [3];
    int lreq [3];
    int nh, nl;
    longint idle;
    duty_now = (m_pwm == 0) ? int'(duty) : m_period_duty;
    on = (m_pwm < duty_now) ? 1 : 0;
    for (int k = 0; k < 3; k++) begin
      hreq[k] = (!stop && !brake && k == hi_leg[m_step] && on == 1) ? 1 : 0;
      lreq[k] = (!stop && (brake || k == lo_leg[m_step])) ? 1 : 0;
    end
    for (int k = 0; k < 3; k++) begin
      idle = m_cyc - m_busy[k] - 1;
      if (m_h[k] == 1) nh = (hreq[k] == 1 && lreq[k] == 0) ? 1 : 0;
      else nh = (hreq[k] == 1 && lreq[k] == 0 && m_l[k] == 0 && idle >= DT) ? 1 : 0;
      if (m_l[k] == 1) nl = (lreq[k] == 1 && hreq[k] == 0) ? 1 : 0;
      else nl = (lreq[k] == 1 && hreq[k] == 0 && m_h[k] == 0 && idle >= DT) ? 1 : 0;
      if (m_h[k] == 1 || m_l[k] == 1) m_busy[k] = m_cyc;
      m_h[k] = nh; m_l[k] = nl;
    end
    m_tick = 0;
    if (latch) begin
      if (pu < 6) m_step = int'(pu);
      m_timer = 0;
    end else if (!stop) begin
      if (div == 0) m_timer = 0;
      else if (longint'(m_timer) + 1 >= longint'(div)) begin
        m_timer = 0;
        m_step = dir ? (m_step + 5) % 6 : (m_step + 1) % 6;
        m_tick = 1;
      end else m_timer = m_timer + 1;
    end
    if (m_pwm == 0) m_period_duty = int'(duty);
    m_pwm = (m_pwm + 1) % PER;
    m_cyc++;
  endtask

  task automatic check_all();
    chk("phase", o_phase, m_step);
    chk("tick", o_tick, m_tick);
    chk("uh", o_uh, m_h[0]); chk("ul", o_ul, m_l[0]);
    chk("vh", o_vh, m_h[1]); chk("vl", o_vl, m_l[1]);
    chk("wh", o_wh, m_h[2]); chk("wl", o_wl, m_l[2]);
    chk("overlap", {o_uh & o_ul, o_vh & o_vl, o_wh & o_wl}, 0);
  endtask

  // Called at a negedge with inputs set; returns at the next negedge.
  task automatic step_clk();
    model_next();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step_clk();
  endtask

  task automatic latch_step(input logic [2:0] v);
    pu = v; latch = 1'b1;
    step_clk();
    latch = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int held, ticks, gates_seen, uh_cnt, wait_n, prev_tick_cyc;
    rst_n = 1'b1; div = 0; stop = 0; dir = 0; latch = 0; brake = 0; duty = 0; pu = 0;
    #2 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    model_reset();
    check_all();
    chk("reset_phase", o_phase, 0);
    rst_n = 1'b1;

    // Forward stepping, iDiv=10, full duty.
    div = 10; dir = 0; duty = 8'd255;
    latch_step(3'd0);
    prev_tick_cyc = int'(m_cyc);
    for (int n = 0; n < 6; n++) begin
      wait_n = 0;
      do begin step_clk(); wait_n++; end while (o_tick !== 1'b1 && wait_n < 40);
      chk("fwd_interval", wait_n, 10);
      chk("fwd_seq", o_phase, (n + 1) % 6);
    end

    // Reverse from step 0.
    dir = 1;
    latch_step(3'd0);
    for (int n = 0; n < 3; n++) begin
      wait_n = 0;
      do begin step_clk(); wait_n++; end while (o_tick !== 1'b1 && wait_n < 40);
      chk("rev_seq", o_phase, 5 - n);
    end

    // Phase latch: valid value loads with no tick, 6/7 ignored.
    latch_step(3'd3);
    chk("latch3_phase", o_phase, 3);
    chk("latch3_tick", o_tick, 0);
    latch_step(3'd7);
    chk("latch7_phase", o_phase, 3);
    latch_step(3'd6);
    chk("latch6_phase", o_phase, 3);

    // PWM duty 64 at step 0, step held.
    div = 0; dir = 0; duty = 8'd64;
    latch_step(3'd0);
    run(600);
    uh_cnt = 0;
    for (int i = 0; i < PER; i++) begin step_clk(); uh_cnt += int'(o_uh); end
    chk("duty64_on", uh_cnt, 64);
    wait_n = 0;
    while (m_pwm != 100 && wait_n < 400) begin step_clk(); wait_n++; end
    duty = 8'd192;
    run(3);
    chk("duty_mid_period", o_uh, 0);
    run(300);
    uh_cnt = 0;
    for (int i = 0; i < PER; i++) begin step_clk(); uh_cnt += int'(o_uh); end
    chk("duty192_on", uh_cnt, 192);

    // Stop for 50 clocks, then resume from the held timer.
    div = 10; duty = 8'd200;
    latch_step(3'd2);
    run(5);
    held = int'(o_phase);
    stop = 1; ticks = 0; gates_seen = 0;
    for (int i = 0; i < 50; i++) begin
      step_clk();
      ticks += int'(o_tick);
      gates_seen |= int'({o_uh, o_ul, o_vh, o_vl, o_wh, o_wl});
    end
    chk("stop_phase", o_phase, held);
    chk("stop_ticks", ticks, 0);
    chk("stop_gates", gates_seen, 0);
    stop = 0;
    wait_n = 0;
    do begin step_clk(); wait_n++; end while (o_tick !== 1'b1 && wait_n < 20);
    chk("stop_resume_clks", wait_n, 5);
    chk("stop_resume_phase", o_phase, 3);

    // Randomized stretch.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom % 50 == 0) div = $urandom_range(0, 12);
      if ($urandom % 16 == 0) dir = 1'($urandom);
      if ($urandom % 30 == 0) stop = ~stop;
      if ($urandom % 64 == 0) duty = PW'($urandom);
`ifdef BLDCM_BRAKE_EN
      if ($urandom % 40 == 0) brake = ~brake;
`endif
      pu = 3'($urandom);
      latch = ($urandom % 25 == 0);
      step_clk();
    end
    latch = 0; stop = 0; brake = 0;

`ifdef BLDCM_BRAKE_EN
    // Active short brake at step 0.
    div = 0; duty = 8'd128;
    latch_step(3'd0);
    run(300);
    brake = 1;
    run(10);
    chk("brake_low", {o_ul, o_vl, o_wl}, 3'b111);
    chk("brake_high", {o_uh, o_vh, o_wh}, 3'b000);
    stop = 1;
    run(2);
    chk("brake_stop", {o_uh, o_ul, o_vh, o_vl, o_wh, o_wl}, 0);
    stop = 0; brake = 0;
    run(20);
`endif

    // Asynchronous reset in the middle of a run.
    div = 10; duty = 8'd128; dir = 0;
    run(27);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gates", {o_uh, o_ul, o_vh, o_vl, o_wh, o_wl}, 0);
    chk("async_rst_phase", o_phase, 0);
    @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
